stitch_pipeline_output_fifo: RTL
================================

Name: stitch_pipeline_output_fifo

Overview:
- Receive-side stage for a stitched, stall-free combinational/register pipeline; the pipeline itself has no backpressure.
- Upstream launch logic asks this block for a credit (issue handshake) before launching a transaction into the pipeline. The result emerges a fixed number of cycles later on in_valid/in_data.
- The block buffers results in a FIFO and presents them downstream with valid/ready. Credits guarantee the FIFO never overflows while the protocol is obeyed.

Parameters:
- DATA_WIDTH, 32, width of one pipeline result word.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy/in-flight counters (derived, not overridden).

Ports:
- clk  input  1  Rising-edge clock.
- rst_n  input  1  Reset.
- issue_valid  input  1  Upstream wants to launch one transaction this cycle.
- issue_ready  output  1  Credit available; launch occurs when issue_valid && issue_ready.
- in_valid  input  1  Pipeline result present this cycle; no backpressure.
- in_data  input  DATA_WIDTH  Pipeline result.
- out_valid  output  1  FIFO head valid.
- out_data  output  DATA_WIDTH  FIFO head; don't-care when out_valid=0.
- out_ready  input  1  Downstream accepts head.
- occupancy  output  CNT_W  Entries currently stored.
- inflight  output  CNT_W  Launched but not yet returned.
- overflow  output  1  Sticky: in_valid seen while FIFO full; the word is dropped.
- proto_err  output  1  Sticky: in_valid seen while inflight==0.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Everything is posedge clk.
- Reset values: occupancy=0, inflight=0, out_valid=0, overflow=0, proto_err=0, issue_ready=1. Read and write pointers reset to 0. Storage array is not reset.
- Reset asserted mid-operation clears all state immediately. Data in flight in the upstream pipeline at reset is the launcher's responsibility; it must also be reset.
- issue_ready is combinational from registers only: issue_ready = (occupancy + inflight) < DEPTH. It never depends on issue_valid or in_valid.
- launch = issue_valid && issue_ready.
- ret = in_valid && (inflight != 0). In the same cycle both launch and ret may occur.
  - Next inflight = inflight + launch - ret.
  - in_valid with inflight==0 sets proto_err. The word is still pushed if space allows, and inflight stays 0 (no underflow).
- push = in_valid && (occupancy < DEPTH).
  - in_valid with occupancy==DEPTH sets overflow and drops the word.
  - A simultaneous pop does not free space for the same-cycle push.
- FIFO is first-word-fall-through:
  - out_valid = (occupancy != 0).
  - out_data = mem[rd_ptr], combinational from the registered pointer and array.
  - pop = out_valid && out_ready.
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- Push to an empty FIFO: out_valid rises the next cycle (latency 1 from in_valid to out_valid). There is no same-cycle bypass.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is a separate counter, so full and empty are unambiguous.
- out_data is stable while out_valid && !out_ready.
- overflow and proto_err clear only on reset.
- Invariant under a legal protocol: occupancy + inflight <= DEPTH. The bench must assert this.

Decomposition:
- Package stitch_pipeline_pkg holds:
  - the default DATA_WIDTH and DEPTH localparams;
  - a count-width function (clog2 of N+1).
- One natural sub-module: stitch_fifo_mem.
  - Parameterised DEPTH x DATA_WIDTH register array.
  - Ports: clk, write enable, write address, write data, read address, read data (combinational read).
  - No reset.
- Credit, counters, pointers and flags stay in the top module.

Test Plan:
- Reset then idle: after rst_n deasserts, issue_ready=1, out_valid=0, occupancy=0, inflight=0, both flags 0.
- Credit exhaustion: DEPTH=4, out_ready=0, issue_valid held high.
  - Exactly 4 launches occur, then issue_ready=0.
  - Returning 0xA,0xB,0xC,0xD two cycles after each launch gives occupancy=4, inflight=0, issue_ready still 0.
- Drain order: from the full state, raise out_ready.
  - out_data reads 0xA,0xB,0xC,0xD on consecutive cycles.
  - issue_ready rises the cycle after the first pop.
  - out_valid falls after the 4th pop.
- Streaming: out_ready=1, continuous launches with returns at latency 2.
  - Sustained one word per cycle; occupancy stays <= 1.
  - Pointer wrap occurs past entry 3 with data order intact over 20 words.
- Simultaneous events at full: occupancy=4, inflight forced to 1 by protocol violation, in_valid=1 and pop in the same cycle.
  - Word is dropped, overflow=1, occupancy=3.
  - Sticky overflow persists until rst_n.
- Protocol error plus asynchronous reset: in_valid with inflight==0 sets proto_err and pushes the word.
  - Asserting rst_n low mid-burst clears out_valid, proto_err and occupancy without a clock edge.

Source files
------------

// File: rtl/stitch_pipeline_pkg.sv
// rtl/stitch_pipeline_pkg.sv - shared defaults and count-width helper for the stitch pipeline output FIFO
package stitch_pipeline_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/stitch_fifo_mem.sv
// rtl/stitch_fifo_mem.sv - DEPTH x DATA_WIDTH register array, synchronous write, combinational read
module stitch_fifo_mem
    import stitch_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stitch_pipeline_output_fifo.sv
// rtl/stitch_pipeline_output_fifo.sv - credit-gated receive FIFO behind a stall-free pipeline
module stitch_pipeline_output_fifo
    import stitch_pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int CNT_W     = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      inflight,
    output logic                  overflow,
    output logic                  proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          launch;
    logic          ret;
    logic          push;
    logic          pop;

    // Credits cover both stored words and words still travelling down the pipeline.
    assign issue_ready = ({1'b0, occupancy} + {1'b0, inflight}) < DEPTH_W;
    assign launch      = issue_valid && issue_ready;
    assign ret         = in_valid && (inflight != '0);
    assign push        = in_valid && (occupancy != DEPTH_C);
    assign out_valid   = (occupancy != '0);
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= '0;
            occupancy <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case ({launch, ret})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_valid && (occupancy == DEPTH_C)) begin
                overflow <= 1'b1;
            end
            if (in_valid && (inflight == '0)) begin
                proto_err <= 1'b1;
            end
        end
    end

    stitch_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule
